// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction table update path.
package bp_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
    localparam int unsigned IDX_MAX_W   = 16;

    // Index is carried at its widest size; the top narrows it to the table size.
    typedef struct packed {
        logic [IDX_MAX_W-1:0] index;
        logic                 taken;
        logic [63:0]          target;
    } upd_rec_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

endpackage

// File: rtl/bpt_update_fifo.sv
// Synchronous FIFO for table update records; a push into a full queue lands
// only when a pop frees a slot in the same cycle.
module bpt_update_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bpt_update_ctrl.sv
// Branch prediction table sequencer: clears the table after reset, then checks
// each tracked prediction against its resolution and queues table updates.
module bpt_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned N_REG      = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IDX_W     = $clog2(N_REG)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [63:0]      if_pc,
    input  logic             if_pred_taken,
    input  logic [63:0]      if_pred_target,
    input  logic             id_is_branch,
    input  logic             id_taken,
    input  logic [63:0]      id_target,
    output logic             flush,
    output logic [63:0]      redirect_pc,
    output logic             pc_hold,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic             upd_clear,
    output logic [IDX_W-1:0] upd_index,
    output logic             upd_taken,
    output logic [63:0]      upd_target,
    output logic [15:0]      drop_count
);

    state_t     state;
    state_t     state_nxt;
    logic [IDX_W-1:0] init_idx;
    logic [IDX_W-1:0] init_idx_nxt;

    logic        trk_valid;
    logic [63:0] trk_pc;
    logic        trk_pt;
    logic [63:0] trk_tgt;

    logic     run;
    logic     resolve;
    logic     act_taken;
    logic     mispredict;
    logic     push;
    logic     pop;
    logic     fifo_full;
    logic     fifo_empty;
    upd_rec_t push_rec;
    upd_rec_t head_rec;

    assign run        = (state == ST_RUN);
    assign resolve    = run & trk_valid & ~stall & (id_is_branch | trk_pt);
    assign act_taken  = id_is_branch & id_taken;
    assign mispredict = resolve & ((trk_pt != act_taken) |
                                   (trk_pt & id_taken & (trk_tgt != id_target)));
    assign flush       = mispredict;
    assign redirect_pc = mispredict ? (act_taken ? id_target : trk_pc + 64'(INSTR_BYTES)) : '0;

    assign push            = resolve;
    assign pop             = run & ~fifo_empty & upd_ready;
    assign push_rec.index  = IDX_MAX_W'(trk_pc[IDX_W+1:2]);
    assign push_rec.taken  = act_taken;
    assign push_rec.target = id_target;

    always_comb begin
        state_nxt    = state;
        init_idx_nxt = init_idx;
        pc_hold      = 1'b0;
        upd_valid    = 1'b0;
        upd_clear    = 1'b0;
        upd_index    = '0;
        upd_taken    = 1'b0;
        upd_target   = '0;
        case (state)
            ST_INIT: begin
                pc_hold   = 1'b1;
                upd_valid = 1'b1;
                upd_clear = 1'b1;
                upd_index = init_idx;
                if (upd_ready) begin
                    if (init_idx == IDX_W'(N_REG - 1)) begin
                        state_nxt    = ST_RUN;
                        init_idx_nxt = '0;
                    end else begin
                        init_idx_nxt = init_idx + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                upd_valid = ~fifo_empty;
                if (!fifo_empty) begin
                    upd_index  = head_rec.index[IDX_W-1:0];
                    upd_taken  = head_rec.taken;
                    upd_target = head_rec.target;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else begin
            state    <= state_nxt;
            init_idx <= init_idx_nxt;
        end
    end

    // A mispredict squashes the instruction entering ID, so it is never tracked.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            trk_valid <= 1'b0;
            trk_pc    <= '0;
            trk_pt    <= 1'b0;
            trk_tgt   <= '0;
        end else if (!stall) begin
            trk_valid <= if_valid & ~flush;
            trk_pc    <= if_pc;
            trk_pt    <= if_pred_taken;
            trk_tgt   <= if_pred_target;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            drop_count <= '0;
        end else if (push && fifo_full && !pop && drop_count != '1) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    bpt_update_fifo #(
        .WIDTH($bits(upd_rec_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .arst (arst),
        .push (push),
        .pop  (pop),
        .din  (push_rec),
        .dout (head_rec),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule

// File: tb/tb_bpt_update_ctrl.sv
// Directed and randomized checks of bpt_update_ctrl against a queue-based reference model.
module tb_bpt_update_ctrl;

    localparam int unsigned NR = 16;
    localparam int unsigned FD = 4;

    logic        clk = 1'b0;
    logic        arst, stall, if_valid, if_pred_taken, id_is_branch, id_taken, upd_ready;
    logic [63:0] if_pc, if_pred_target, id_target;
    logic        flush, pc_hold, upd_valid, upd_clear, upd_taken;
    logic [63:0] redirect_pc, upd_target;
    logic [3:0]  upd_index;
    logic [15:0] drop_count;

    bpt_update_ctrl #(.N_REG(NR), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .arst(arst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .id_is_branch(id_is_branch), .id_taken(id_taken), .id_target(id_target),
        .flush(flush), .redirect_pc(redirect_pc), .pc_hold(pc_hold),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_clear(upd_clear),
        .upd_index(upd_index), .upd_taken(upd_taken), .upd_target(upd_target),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        bit          tk;
        logic [63:0] tgt;
    } rec_t;

    rec_t        q[$];
    bit          m_run;
    int unsigned m_idx;
    int unsigned m_drop;
    bit          m_tv, m_tpt;
    logic [63:0] m_tpc, m_ttgt;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 0; m_idx = 0; m_drop = 0;
        m_tv = 0; m_tpt = 0; m_tpc = '0; m_ttgt = '0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        bit          res, act, mis, exp_valid;
        logic [63:0] exp_redir;
        @(negedge clk);
        if (arst) model_reset();
        act = id_is_branch && id_taken;
        res = m_run && m_tv && !stall && (id_is_branch || m_tpt);
        mis = res && ((m_tpt != act) || (m_tpt && id_taken && m_ttgt != id_target));
        exp_redir = !mis ? 64'd0 : (act ? id_target : m_tpc + 64'd4);
        exp_valid = m_run ? (q.size() != 0) : 1'b1;
        chk("flush", flush, mis);
        chk("redirect_pc", redirect_pc, exp_redir);
        chk("pc_hold", pc_hold, !m_run);
        chk("upd_clear", upd_clear, !m_run);
        chk("upd_valid", upd_valid, exp_valid);
        chk("drop_count", drop_count, m_drop);
        if (!m_run) begin
            chk("init_index", upd_index, m_idx);
            if (arst) begin
                chk("rst_taken", upd_taken, 0);
                chk("rst_target", upd_target, 0);
            end
        end else if (exp_valid) begin
            chk("upd_index", upd_index, q[0].idx);
            chk("upd_taken", upd_taken, q[0].tk);
            chk("upd_target", upd_target, q[0].tgt);
        end
        if (!arst) begin
            if (!m_run) begin
                if (upd_ready) begin
                    if (m_idx == NR - 1) begin m_run = 1; m_idx = 0; end
                    else m_idx++;
                end
            end else begin
                if (exp_valid && upd_ready) void'(q.pop_front());
                if (res) begin
                    if (q.size() < FD) q.push_back('{idx: (m_tpc >> 2) % NR, tk: act, tgt: id_target});
                    else if (m_drop < 16'hFFFF) m_drop++;
                end
            end
            if (!stall) begin
                m_tv = if_valid && !mis;
                m_tpc = if_pc; m_tpt = if_pred_taken; m_ttgt = if_pred_target;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] pc, input bit pt, input logic [63:0] ptgt,
                         input bit br, input bit tk, input logic [63:0] tgt);
        if_valid = v; if_pc = pc; if_pred_taken = pt; if_pred_target = ptgt;
        id_is_branch = br; id_taken = tk; id_target = tgt;
    endtask

    initial begin
        arst = 1; stall = 0; upd_ready = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        step();
        step();
        arst = 0;

        // Table clear: 16 commands, indices 0..15
        for (int i = 0; i < 16; i++) step();
        chk("pc_hold_after_init", pc_hold, 0);
        chk("drop_after_init", drop_count, 0);

        // Not-taken prediction resolves taken
        drive(1, 64'h100, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 1, 64'h200); step();
        chk("rec1_index", upd_index, 0);
        chk("rec1_taken", upd_taken, 1);
        chk("rec1_target", upd_target, 64'h200);

        // Non-branch predicted taken
        drive(1, 64'h104, 1, 64'h300, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0); step();
        chk("rec2_index", upd_index, 1);
        chk("rec2_taken", upd_taken, 0);

        // Correct taken prediction still pushes a record
        drive(1, 64'h3C, 1, 64'h40, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 1, 64'h40); step();
        chk("rec3_index", upd_index, 15);
        chk("rec3_taken", upd_taken, 1);

        // PC wrap on fall-through redirect
        drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h8, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) step();

        // Overflow: 6 resolutions against a stalled table
        upd_ready = 0;
        drive(1, 64'h200, 0, 0, 0, 0, 0); step();
        for (int i = 1; i <= 6; i++) begin
            drive(i != 6, 64'h200 + 64'(4 * i), 0, 0, 1, 0, 64'h500 + 64'(i));
            step();
        end
        chk("drop_count_overflow", drop_count, 2);
        drive(0, 0, 0, 0, 0, 0, 0);
        upd_ready = 1;
        for (int i = 0; i < 5; i++) step();
        chk("drained", upd_valid, 0);

        // Reset in the middle of the clear sequence
        arst = 1; step(); arst = 0;
        for (int i = 0; i < 7; i++) step();
        chk("mid_init_idx", upd_index, 7);
        arst = 1; step();
        chk("restart_idx", upd_index, 0);
        arst = 0;
        for (int i = 0; i < 18; i++) step();

        // Randomized traffic including stalls and backpressure
        arst = 1; step(); arst = 0;
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            upd_ready = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom} & ~64'd3, 1'($urandom),
                  64'h1000 + 64'(4 * $urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  64'h1000 + 64'(4 * $urandom_range(0, 3)));
            if (i == 300) arst = 1;
            else arst = 0;
            step();
        end
        arst = 0; stall = 0; upd_ready = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
